gearbox_resetgen: RTL and testbench
===================================

# gearbox_resetgen

Parametrised clock-enable gearbox and reset sequencer for FemtoRV-class designs. It takes the single design clock and the board reset, and produces a synchronised, timed active-low reset for the rest of the design. It also generates NCH independent clock-enable pulse trains with run-time programmable division ratios, so slow peripherals and "watch it run" demos use clock enables instead of derived clocks. An optional single-step mode lets a button advance all channels one enable pulse at a time.

## Interface
- NCH, 2, number of clock-enable channels (1..8)
- DIV_W, 16, width of each channel divider value
- HOLD_W, 16, reset hold counter width; hold lasts 2^HOLD_W cycles (12 fits IceStick)
- SYNC_STAGES, 2, reset and step synchroniser depth (>=2)

- clk  in  1  design clock, all logic on posedge
- resetn  in  1  asynchronous active-low reset; asserts immediately, deasserts through the synchroniser
- ext_rst_req  in  1  synchronous active-high request to rerun the reset sequence
- div  in  NCH*DIV_W  per-channel divide value; channel i uses div[i*DIV_W +: DIV_W]
- step_mode  in  1  1 = single-step mode (only with GEARBOX_STEP_EN)
- step_req  in  1  asynchronous step button, active high
- rst_out_n  out  1  timed active-low design reset, deasserts synchronously
- ce  out  NCH  one-cycle clock-enable pulses, one bit per channel

## Operation
- Reset sync: SYNC_STAGES-flop chain. Asynchronous clear on resetn=0. Shifts in 1 each edge. Output rst_sync_n.
- Sequencer states:
  - HOLD: hold_cnt increments each edge while rst_sync_n=1. It saturates at 2^HOLD_W-1.
  - On the edge where hold_cnt is already all-ones, go to RUN and set rst_out_n=1.
  - RUN: if ext_rst_req=1 at an edge, clear hold_cnt, set rst_out_n=0, and return to HOLD. ext_rst_req is ignored in HOLD.
- resetn=0 at any time, including mid-HOLD or mid-RUN, asynchronously resets everything:
  - hold_cnt, synchroniser, channel counters, step logic and ce all go to 0.
  - rst_out_n goes to 0 and the state goes to HOLD.
- Channel i, free-run (RUN and not step mode):
  - cnt_i counts 0..div_i.
  - When cnt_i >= div_i: cnt_i goes to 0 and ce[i]=1 for the next cycle. Otherwise cnt_i increments and ce[i]=0.
  - Period is div_i+1 cycles. div_i=0 gives ce[i] constantly 1.
  - Lowering div_i below cnt_i causes a wrap on the next edge; there is no long count-out.
- ce is registered and is 0 whenever the state is not RUN. The cycle rst_out_n rises, all cnt_i are 0.
- Channels are independent; simultaneous pulses on several channels are normal.

## Timing
- Reset values: rst_out_n=0, ce=0.
- rst_out_n rises on edge SYNC_STAGES + 2^HOLD_W, counting resetn deassertion as edge 0 (and assuming no ext_rst_req).
- ext_rst_req sampled at edge k gives rst_out_n=0 and ce=0 after edge k. rst_out_n rises again after edge k + 2^HOLD_W.
- ext_rst_req together with a wrap: reset wins and no ce pulse is issued.
- First ce[i] pulse appears after edge div_i+1 following rst_out_n rising.
- Step latency:
  - step_req rising is seen at synchroniser edge s.
  - ce (all channels) is high for exactly one cycle after edge s+SYNC_STAGES.
  - Holding step_req produces one pulse only; the next pulse needs a low then high transition.

## Configuration
- GEARBOX_STEP_EN defined:
  - step_mode=1 freezes all cnt_i; free-run ce is suppressed.
  - Each synchronised rising edge of step_req gives a one-cycle pulse on all ce bits. Counters are untouched.
  - step_mode=0 resumes from the held cnt_i values.
  - A step edge while not in RUN is discarded.
- GEARBOX_STEP_EN undefined:
  - step_mode and step_req are ignored; the ports remain.
  - The step synchroniser and edge detector are not built.

## Test plan
- HOLD_W=4, SYNC_STAGES=2, release resetn at edge 0 -> rst_out_n=0 through edge 17, 1 from edge 18; ce=0 throughout.
- NCH=2, div={3,0} after rst_out_n rises -> ce[0] pulses every 4 cycles with first pulse after edge 4; ce[1] constantly 1.
- div_0 changed 9->2 while cnt_0=7 -> ce[0] pulse on the next cycle, then period 3.
- ext_rst_req for 1 cycle in RUN -> rst_out_n=0 and ce=0 next cycle, rst_out_n=1 again 16 cycles later; ext_rst_req coinciding with a wrap gives no pulse.
- resetn pulsed low mid-HOLD and mid-RUN -> rst_out_n and ce go to 0 asynchronously, and the full 18-cycle sequence restarts.
- GEARBOX_STEP_EN, step_mode=1, step_req held 20 cycles -> exactly one all-ones ce pulse, 2 cycles after the synchronised rising edge; clearing step_mode resumes from the frozen counts.

Source files
------------

// File: rtl/gearbox_resetgen.sv
// Reset sequencer plus NCH clock-enable dividers with run-time divide values.
// Define GEARBOX_STEP_EN to build the single-step (button-advanced) mode.
module gearbox_resetgen #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned HOLD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ext_rst_req,
  input  logic [NCH*DIV_W-1:0]   div,
  input  logic                   step_mode,
  input  logic                   step_req,
  output logic                   rst_out_n,
  output logic [NCH-1:0]         ce
);

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  rst_sync_q;
  logic                    rst_sync_n;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [DIV_W-1:0]        cnt   [NCH];
  logic [DIV_W-1:0]        div_c [NCH];
  logic                    step_rise_c;
  logic                    step_hold_c;

  // Board reset synchroniser: asserts immediately, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < NCH; g++) begin : g_div
    assign div_c[g] = div[g*DIV_W +: DIV_W];
  end

`ifdef GEARBOX_STEP_EN
  logic [SYNC_STAGES-1:0] step_sync_q;
  logic                   step_prev_q;

  // Step button synchroniser and rising-edge detector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_sync_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_req};
      step_prev_q <= step_sync_q[SYNC_STAGES-1];
    end
  end

  assign step_rise_c = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;
  assign step_hold_c = step_mode;
`else
  logic unused_step_c;

  assign unused_step_c = step_mode ^ step_req;
  assign step_rise_c   = 1'b0;
  assign step_hold_c   = 1'b0;
`endif

  // Sequencer and channel dividers; counters are held at zero outside RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      rst_out_n <= 1'b0;
      ce        <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          ce <= '0;
          for (int unsigned i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
          end
          if (rst_sync_n) begin
            if (&hold_cnt) begin
              state     <= ST_RUN;
              rst_out_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        ST_RUN: begin
          if (ext_rst_req) begin
            // Reset request beats any wrap landing on the same edge.
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            rst_out_n <= 1'b0;
            ce        <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
              cnt[i] <= '0;
            end
          end else if (step_hold_c) begin
            ce <= {NCH{step_rise_c}};
          end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
              if (cnt[i] >= div_c[i]) begin
                cnt[i] <= '0;
                ce[i]  <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + DIV_W'(1);
                ce[i]  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state     <= ST_HOLD;
          hold_cnt  <= '0;
          rst_out_n <= 1'b0;
          ce        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gearbox_resetgen.sv
// Directed bench for gearbox_resetgen with HOLD_W=4, SYNC_STAGES=2, NCH=2.
module tb_gearbox_resetgen;

  localparam int unsigned NCH         = 2;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned HOLD_W      = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic                 clk;
  logic                 resetn;
  logic                 ext_rst_req;
  logic [NCH*DIV_W-1:0] div;
  logic                 step_mode;
  logic                 step_req;
  logic                 rst_out_n;
  logic [NCH-1:0]       ce;

  int checks = 0;
  int fails  = 0;

  gearbox_resetgen #(
    .NCH(NCH), .DIV_W(DIV_W), .HOLD_W(HOLD_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .resetn(resetn), .ext_rst_req(ext_rst_req), .div(div),
    .step_mode(step_mode), .step_req(step_req), .rst_out_n(rst_out_n), .ce(ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; ext_rst_req = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    div = {16'd0, 16'd3};
    repeat (3) tick();
    checks++;
    if ({rst_out_n, ce} !== 3'b000) begin
      fails++; $display("FAIL reset_values: got rst_out_n=%b ce=%b expected 0 00", rst_out_n, ce);
    end
    resetn = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      checks++;
      if ({rst_out_n, ce} !== 3'b000) begin
        fails++; $display("FAIL reset_hold edge %0d: got rst_out_n=%b ce=%b expected 0 00", e, rst_out_n, ce);
      end
    end
    tick();
    checks++;
    if ({rst_out_n, ce} !== 3'b100) begin
      fails++; $display("FAIL reset_release edge 18: got rst_out_n=%b ce=%b expected 1 00", rst_out_n, ce);
    end
  endtask

  task automatic test_free_run;
    for (int j = 1; j <= 12; j++) begin
      logic [1:0] exp;
      tick();
      exp = {1'b1, (j % 4) == 0};
      checks++;
      if ({rst_out_n, ce} !== {1'b1, exp}) begin
        fails++; $display("FAIL free_run cycle %0d: got rst_out_n=%b ce=%b expected 1 %b", j, rst_out_n, ce, exp);
      end
    end
  endtask

  task automatic test_div_change;
    div[15:0] = 16'd9;
    for (int j = 1; j <= 7; j++) begin
      tick();
      checks++;
      if (ce !== 2'b10) begin
        fails++; $display("FAIL div9_count cycle %0d: got ce=%b expected 10", j, ce);
      end
    end
    div[15:0] = 16'd2;
    tick();
    checks++;
    if (ce !== 2'b11) begin
      fails++; $display("FAIL div_lowered_wrap: got ce=%b expected 11", ce);
    end
    for (int j = 1; j <= 6; j++) begin
      logic [1:0] exp;
      tick();
      exp = {1'b1, (j % 3) == 0};
      checks++;
      if (ce !== exp) begin
        fails++; $display("FAIL div2_period cycle %0d: got ce=%b expected %b", j, ce, exp);
      end
    end
  endtask

  task automatic test_ext_rst;
    repeat (2) tick();
    checks++;
    if (ce !== 2'b10) begin
      fails++; $display("FAIL pre_ext_rst: got ce=%b expected 10", ce);
    end
    ext_rst_req = 1'b1;
    tick();
    ext_rst_req = 1'b0;
    checks++;
    if ({rst_out_n, ce} !== 3'b000) begin
      fails++; $display("FAIL ext_rst_on_wrap: got rst_out_n=%b ce=%b expected 0 00", rst_out_n, ce);
    end
    for (int j = 1; j <= 15; j++) begin
      if (j == 5) ext_rst_req = 1'b1;
      tick();
      ext_rst_req = 1'b0;
      checks++;
      if ({rst_out_n, ce} !== 3'b000) begin
        fails++; $display("FAIL ext_rst_hold cycle %0d: got rst_out_n=%b ce=%b expected 0 00", j, rst_out_n, ce);
      end
    end
    tick();
    checks++;
    if ({rst_out_n, ce} !== 3'b100) begin
      fails++; $display("FAIL ext_rst_release: got rst_out_n=%b ce=%b expected 1 00", rst_out_n, ce);
    end
    for (int j = 1; j <= 3; j++) begin
      logic [1:0] exp;
      tick();
      exp = {1'b1, j == 3};
      checks++;
      if (ce !== exp) begin
        fails++; $display("FAIL post_ext_rst cycle %0d: got ce=%b expected %b", j, ce, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({rst_out_n, ce} !== 3'b000) begin
      fails++; $display("FAIL async_reset_run: got rst_out_n=%b ce=%b expected 0 00", rst_out_n, ce);
    end
    repeat (2) tick();
    resetn = 1'b1;
    repeat (8) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if ({rst_out_n, ce} !== 3'b000) begin
      fails++; $display("FAIL async_reset_hold: got rst_out_n=%b ce=%b expected 0 00", rst_out_n, ce);
    end
    tick();
    resetn = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      checks++;
      if ({rst_out_n, ce} !== 3'b000) begin
        fails++; $display("FAIL restart_hold edge %0d: got rst_out_n=%b ce=%b expected 0 00", e, rst_out_n, ce);
      end
    end
    tick();
    checks++;
    if ({rst_out_n, ce} !== 3'b100) begin
      fails++; $display("FAIL restart_release edge 18: got rst_out_n=%b ce=%b expected 1 00", rst_out_n, ce);
    end
  endtask

`ifdef GEARBOX_STEP_EN
  task automatic test_step;
    tick();
    checks++;
    if (ce !== 2'b10) begin
      fails++; $display("FAIL step_pre: got ce=%b expected 10", ce);
    end
    step_mode = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (ce !== 2'b00) begin
        fails++; $display("FAIL step_frozen cycle %0d: got ce=%b expected 00", j, ce);
      end
    end
    for (int p = 0; p < 2; p++) begin
      step_req = 1'b1;
      for (int j = 1; j <= 20; j++) begin
        logic [1:0] exp;
        tick();
        exp = (j == 3) ? 2'b11 : 2'b00;
        checks++;
        if (ce !== exp) begin
          fails++; $display("FAIL step_pulse press %0d cycle %0d: got ce=%b expected %b", p, j, ce, exp);
        end
      end
      step_req = 1'b0;
      repeat (4) tick();
    end
    step_mode = 1'b0;
    tick();
    checks++;
    if (ce !== 2'b10) begin
      fails++; $display("FAIL step_resume_1: got ce=%b expected 10", ce);
    end
    tick();
    checks++;
    if (ce !== 2'b11) begin
      fails++; $display("FAIL step_resume_2: got ce=%b expected 11", ce);
    end
  endtask
`else
  task automatic test_step_ignored;
    step_mode = 1'b1;
    step_req  = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      logic [1:0] exp;
      tick();
      exp = {1'b1, (j % 3) == 0};
      checks++;
      if (ce !== exp) begin
        fails++; $display("FAIL step_ignored cycle %0d: got ce=%b expected %b", j, ce, exp);
      end
    end
    step_mode = 1'b0;
    step_req  = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_div_change();
    test_ext_rst();
    test_async_reset();
`ifdef GEARBOX_STEP_EN
    test_step();
`else
    test_step_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
